traffic_light_monitor: RTL and testbench

- Observes the red/orange/green lamp drive of the traffic light controller, on the same clk, and checks it.
- Decodes the lamp pattern into a phase.
- Checks one-hot encoding, the red→orange→green→red order, and the length of each phase in clock cycles.
- Reports pulsed and sticky faults plus a count of completed cycles, for a supervisor or a bench scoreboard.

---
 rtl/traffic_light_pkg.sv | 45 ++++
 rtl/traffic_light_monitor_phase_timer.sv | 47 ++++
 rtl/traffic_light_monitor.sv | 186 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light monitor.
// Phase encoding, lamp patterns, default phase lengths and phase helpers.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_ORANGE = 2'd2,
        PH_GREEN  = 2'd3
    } phase_t;

    localparam int DEF_RED_CYCLES    = 9;
    localparam int DEF_ORANGE_CYCLES = 3;
    localparam int DEF_GREEN_CYCLES  = 4;

    // Lamp patterns as {red, orange, green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_ORANGE = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Legal next phase; PH_NONE has no successor
    function automatic phase_t phase_succ(input phase_t p);
        phase_t s;
        case (p)
            PH_RED:    s = PH_ORANGE;
            PH_ORANGE: s = PH_GREEN;
            PH_GREEN:  s = PH_RED;
            default:   s = PH_NONE;
        endcase
        return s;
    endfunction

    // Map a lamp sample to a phase; anything not one-hot is PH_NONE
    function automatic phase_t lamp_decode(input logic [2:0] l);
        phase_t p;
        case (l)
            LAMP_RED:    p = PH_RED;
            LAMP_ORANGE: p = PH_ORANGE;
            LAMP_GREEN:  p = PH_GREEN;
            default:     p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_phase_timer.sv
// Saturating phase-duration counter with load-to-1 and clear.
// Flags the increment that takes the count one past the length.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] count,
    output logic             overlong
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear beats load beats a saturating increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = CNT_ONE;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count+1 == len+1 reduces to count == len on an increment
    assign overlong = inc && !clear && !load && (count_q == len);
    assign count    = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks a red/orange/green lamp drive for one-hot, order and timing.
// Locks on red->orange, then flags pulsed and sticky faults and counts cycles.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int ORANGE_CYCLES = DEF_ORANGE_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             orange,
    input  logic             green,
    input  logic             clear_fault,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err_onehot,
    output logic             err_sequence,
    output logic             err_duration,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } mon_state_t;

    localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

    mon_state_t       state_d, state_q;
    phase_t           prev_d, prev_q;
    phase_t           phase_d, phase_q;
    logic             locked_d, locked_q;
    logic             err_onehot_d, err_onehot_q;
    logic             err_sequence_d, err_sequence_q;
    logic             err_duration_d, err_duration_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] cycle_count_d, cycle_count_q;

    phase_t           lamp_ph;
    logic             lamp_valid;
    logic             lamp_same;
    logic             lamp_next;
    logic             lock_edge;

    logic             tmr_clear;
    logic             tmr_load;
    logic             tmr_inc;
    logic [CNT_W-1:0] tmr_len;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_overlong;

    // Required length of a phase in cycles
    function automatic logic [CNT_W-1:0] phase_len(input phase_t p);
        logic [CNT_W-1:0] n;
        case (p)
            PH_RED:    n = CNT_W'(RED_CYCLES);
            PH_ORANGE: n = CNT_W'(ORANGE_CYCLES);
            PH_GREEN:  n = CNT_W'(GREEN_CYCLES);
            default:   n = '0;
        endcase
        return n;
    endfunction

    // Classify the current lamp sample against the previous phase
    always_comb begin
        lamp_ph    = lamp_decode({red, orange, green});
        lamp_valid = (lamp_ph != PH_NONE);
        lamp_same  = (lamp_ph == prev_q);
        lamp_next  = (lamp_ph == phase_succ(prev_q));
        lock_edge  = (prev_q == PH_RED) && (lamp_ph == PH_ORANGE);
        tmr_len    = phase_len(prev_q);
    end

    // Next-state, checks and timer control
    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        phase_d        = phase_q;
        locked_d       = locked_q;
        err_onehot_d   = 1'b0;
        err_sequence_d = 1'b0;
        err_duration_d = 1'b0;
        cycle_count_d  = cycle_count_q;
        tmr_clear      = 1'b0;
        tmr_load       = 1'b0;
        tmr_inc        = 1'b0;

        if (!lamp_valid) begin
            err_onehot_d = 1'b1;
            state_d      = ST_ACQUIRE;
            prev_d       = PH_NONE;
            phase_d      = PH_NONE;
            locked_d     = 1'b0;
            tmr_clear    = 1'b1;
        end else if (state_q == ST_ACQUIRE) begin
            // No checks while acquiring; just follow the lamps
            prev_d = lamp_ph;
            if (lamp_same) begin
                tmr_inc = 1'b1;
            end else begin
                tmr_load = 1'b1;
            end
            if (lock_edge) begin
                state_d  = ST_TRACK;
                locked_d = 1'b1;
                phase_d  = PH_ORANGE;
            end
        end else if (lamp_same) begin
            tmr_inc        = 1'b1;
            err_duration_d = tmr_overlong;
        end else if (lamp_next) begin
            // Overlong was already reported while the phase ran on
            err_duration_d = (tmr_count < tmr_len);
            tmr_load       = 1'b1;
            prev_d         = lamp_ph;
            phase_d        = lamp_ph;
            if (lamp_ph == PH_RED) begin
                cycle_count_d = cycle_count_q + CYC_ONE;
            end
        end else begin
            err_sequence_d = 1'b1;
            state_d        = ST_ACQUIRE;
            prev_d         = PH_NONE;
            phase_d        = PH_NONE;
            locked_d       = 1'b0;
            tmr_clear      = 1'b1;
        end

        // A new error on the clearing edge keeps the fault set
        fault_d = (fault_q && !clear_fault)
                | err_onehot_d
                | err_sequence_d
                | err_duration_d;
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ACQUIRE;
            prev_q         <= PH_NONE;
            phase_q        <= PH_NONE;
            locked_q       <= 1'b0;
            err_onehot_q   <= 1'b0;
            err_sequence_q <= 1'b0;
            err_duration_q <= 1'b0;
            fault_q        <= 1'b0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            phase_q        <= phase_d;
            locked_q       <= locked_d;
            err_onehot_q   <= err_onehot_d;
            err_sequence_q <= err_sequence_d;
            err_duration_q <= err_duration_d;
            fault_q        <= fault_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .inc      (tmr_inc),
        .len      (tmr_len),
        .count    (tmr_count),
        .overlong (tmr_overlong)
    );

    assign locked       = locked_q;
    assign phase        = phase_q;
    assign err_onehot   = err_onehot_q;
    assign err_sequence = err_sequence_q;
    assign err_duration = err_duration_q;
    assign fault        = fault_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random lamp
// traffic, each sample checked against a rule-level reference model.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       red, orange, green;
    logic       clear_fault;
    logic       locked;
    logic [1:0] phase;
    logic       err_onehot, err_sequence, err_duration;
    logic       fault;
    logic [7:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_lock;
    int m_prev;
    int m_run;
    int m_cyc;
    bit m_fault;
    bit m_eo, m_es, m_ed;

    int nom[3] = '{9, 3, 4};
    logic [2:0] lmp[3] = '{3'b100, 3'b010, 3'b001};

    traffic_light_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .red          (red),
        .orange       (orange),
        .green        (green),
        .clear_fault  (clear_fault),
        .locked       (locked),
        .phase        (phase),
        .err_onehot   (err_onehot),
        .err_sequence (err_sequence),
        .err_duration (err_duration),
        .fault        (fault),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lamp_phase(input logic [2:0] l);
        if ($countones(l) != 1) return 0;
        if (l[2]) return 1;
        if (l[1]) return 2;
        return 3;
    endfunction

    function automatic int plen(input int p);
        return nom[p-1];
    endfunction

    task automatic model_reset();
        m_lock = 0; m_prev = 0; m_run = 0;
        m_cyc = 0; m_fault = 0;
        m_eo = 0; m_es = 0; m_ed = 0;
    endtask

    task automatic model(input logic [2:0] l, input logic clr);
        int ph;
        ph = lamp_phase(l);
        m_eo = 0; m_es = 0; m_ed = 0;
        if (ph == 0) begin
            m_eo = 1; m_lock = 0; m_prev = 0; m_run = 0;
        end else if (!m_lock) begin
            if (m_prev == 1 && ph == 2) begin
                m_lock = 1; m_prev = 2; m_run = 1;
            end else if (ph == m_prev) begin
                m_run++;
            end else begin
                m_prev = ph; m_run = 1;
            end
        end else if (ph == m_prev) begin
            m_run++;
            if (m_run == plen(m_prev) + 1) m_ed = 1;
        end else if (ph == m_prev % 3 + 1) begin
            if (m_run < plen(m_prev)) m_ed = 1;
            if (ph == 1) m_cyc = (m_cyc + 1) % 256;
            m_prev = ph; m_run = 1;
        end else begin
            m_es = 1; m_lock = 0; m_prev = 0; m_run = 0;
        end
        if (clr) m_fault = 0;
        if (m_eo || m_es || m_ed) m_fault = 1;
    endtask

    task automatic check_all();
        chk("locked", locked, m_lock);
        chk("phase", phase, m_lock ? m_prev : 0);
        chk("err_onehot", err_onehot, m_eo);
        chk("err_sequence", err_sequence, m_es);
        chk("err_duration", err_duration, m_ed);
        chk("fault", fault, m_fault);
        chk("cycle_count", cycle_count, m_cyc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_eo"}, err_onehot, 0);
        chk({tag, "_es"}, err_sequence, 0);
        chk({tag, "_ed"}, err_duration, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_cyc"}, cycle_count, 0);
    endtask

    // Called at a negedge; returns at the next negedge after checking
    task automatic step(input logic [2:0] l, input logic clr);
        {red, orange, green} = l;
        clear_fault = clr;
        @(posedge clk);
        model(l, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic legal(input int nr, input int no, input int ng);
        repeat (nr) step(3'b100, 1'b0);
        repeat (no) step(3'b010, 1'b0);
        repeat (ng) step(3'b001, 1'b0);
    endtask

    initial begin
        int n;
        logic [2:0] l;
        logic c;

        reset = 1'b1;
        {red, orange, green} = 3'b000;
        clear_fault = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Clean controller sequence from reset
        repeat (9) step(3'b100, 1'b0);
        chk("acq_after9", locked, 0);
        step(3'b010, 1'b0);
        chk("lock_10th", locked, 1);
        chk("lock_phase", phase, 2);
        repeat (2) step(3'b010, 1'b0);
        repeat (4) step(3'b001, 1'b0);
        step(3'b100, 1'b0);
        chk("cyc_first", cycle_count, 1);
        repeat (8) step(3'b100, 1'b0);
        repeat (3) step(3'b010, 1'b0);
        repeat (4) step(3'b001, 1'b0);
        legal(9, 3, 4);
        legal(9, 3, 4);
        chk("clean_fault", fault, 0);
        chk("clean_cyc", cycle_count, 3);

        // Orange held for 5 cycles
        repeat (9) step(3'b100, 1'b0);
        repeat (3) step(3'b010, 1'b0);
        step(3'b010, 1'b0);
        chk("long_or_ed", err_duration, 1);
        chk("long_or_lock", locked, 1);
        step(3'b010, 1'b0);
        chk("long_or_once", err_duration, 0);
        repeat (4) step(3'b001, 1'b0);
        chk("long_or_fault", fault, 1);

        // Green cut short at 2 cycles
        repeat (9) step(3'b100, 1'b0);
        repeat (3) step(3'b010, 1'b0);
        repeat (2) step(3'b001, 1'b0);
        step(3'b100, 1'b0);
        chk("short_gr_ed", err_duration, 1);
        chk("short_gr_cyc", cycle_count, 6);

        // Red straight to green, then relock
        step(3'b001, 1'b0);
        chk("seq_es", err_sequence, 1);
        chk("seq_lock", locked, 0);
        chk("seq_cyc", cycle_count, 6);
        repeat (9) step(3'b100, 1'b0);
        step(3'b010, 1'b0);
        chk("relock", locked, 1);

        // Bad lamp patterns with a coincident clear
        step(3'b000, 1'b0);
        chk("oh_000", err_onehot, 1);
        step(3'b110, 1'b1);
        chk("oh_110", err_onehot, 1);
        chk("oh_clr_fault", fault, 1);
        step(3'b100, 1'b1);
        chk("clr_fault", fault, 0);

        // Async reset mid-green with three counted cycles
        @(negedge clk);
        #2 reset = 1'b1;
        #1 model_reset();
        check_zero("rst_a");
        @(negedge clk);
        reset = 1'b0;
        legal(9, 3, 4);
        legal(9, 3, 4);
        legal(9, 3, 4);
        legal(9, 3, 4);
        repeat (2) step(3'b001, 1'b0);
        chk("pre_rst_cyc", cycle_count, 3);
        #2 reset = 1'b1;
        #1 model_reset();
        check_zero("rst_b");
        @(negedge clk);
        reset = 1'b0;
        legal(9, 3, 4);
        legal(9, 3, 4);
        chk("reacq_lock", locked, 1);

        // Random lamp traffic around the legal pattern
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 3; p++) begin
                n = nom[p];
                if ($urandom_range(0, 9) < 3)
                    n = nom[p] + int'($urandom_range(0, 4)) - 2;
                if ($urandom_range(0, 14) == 0)
                    n = 0;
                for (int j = 0; j < n; j++) begin
                    l = lmp[p];
                    if ($urandom_range(0, 49) == 0)
                        l = 3'($urandom);
                    c = ($urandom_range(0, 19) == 0);
                    step(l, c);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
